// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
// Optional SEQ_DIVIDER_SELFCHECK_EN adds chk_err: q*d+r is checked against the dividend on each result.
module seq_divider #(
  parameter int DIVIDEND_W = 6,
  parameter int DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  ,
  output logic                  chk_err
`endif
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam int PR_W  = DIVISOR_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  zero_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  dbz_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;

  logic                  accept;
  logic [PR_W-1:0]       shifted;
  logic                  trial_neg;
  logic [DIVISOR_W-1:0]  trial_rem;
  logic [DIVISOR_W-1:0]  rem_d;
  logic [DIVIDEND_W-1:0] quo_d;

  assign accept  = start && (state_q != S_RUN);
  assign shifted = {rem_q, dvd_q[DIVIDEND_W-1]};
  // rem_q < dvs_q always holds, so the PR_W-bit difference cannot overflow and its MSB is the borrow.
  assign {trial_neg, trial_rem} = shifted - {1'b0, dvs_q};
  assign rem_d = trial_neg ? shifted[DIVISOR_W-1:0] : trial_rem;
  assign quo_d = {quo_q[DIVIDEND_W-2:0], ~trial_neg};

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  localparam int PROD_W = DIVIDEND_W + DIVISOR_W + 1;
  logic [DIVIDEND_W-1:0] op_dvd_q;
  logic                  chk_err_q;
  logic [PROD_W-1:0]     recon;

  assign recon   = PROD_W'(quo_q) * PROD_W'(dvs_q) + PROD_W'(rem_q);
  assign chk_err = chk_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
      op_dvd_q    <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
      chk_err_q <= 1'b0;
`endif
      // Results are published only while leaving DONE, so partial values never reach the outputs.
      if (state_q == S_DONE) begin
        done_q      <= 1'b1;
        quotient_q  <= quo_q;
        remainder_q <= rem_q;
        dbz_q       <= zero_q;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
        chk_err_q   <= !zero_q && (recon != PROD_W'(op_dvd_q));
`endif
      end

      if (accept) begin
        cnt_q <= CNT_INIT;
        dvs_q <= divisor;
        dvd_q <= dividend;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
        op_dvd_q <= dividend;
`endif
        if (divisor == '0) begin
          quo_q   <= '1;
          rem_q   <= dividend[DIVISOR_W-1:0];
          zero_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end else begin
          quo_q   <= '0;
          rem_q   <= '0;
          zero_q  <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_RUN;
        end
      end else begin
        case (state_q)
          S_RUN: begin
            dvd_q <= dvd_q << 1;
            quo_q <= quo_d;
            rem_q <= rem_d;
            if (cnt_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against a behavioural division model
module tb_seq_divider;
  localparam int DW = 6;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic          chk_err;
`endif

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
`ifdef SEQ_DIVIDER_SELFCHECK_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dvs;
    int acc;
  } op_t;

  op_t pend[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  checking = 1'b0;
  int  last_q = 0;
  int  last_r = 0;
  int  last_z = 0;
  op_t ce;
  int  cq, cr, cz, bexp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input op_t e);
    return (e.dvs == 0) ? 1 : DW + 1;
  endfunction

  task automatic model(input op_t e, output int q, output int r, output int z);
    if (e.dvs == 0) begin
      q = (1 << DW) - 1;
      r = e.dvd % (1 << VW);
      z = 1;
    end else begin
      q = e.dvd / e.dvs;
      r = e.dvd % e.dvs;
      z = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && checking) begin
      bexp = 0;
      foreach (pend[i])
        if (pend[i].dvs != 0 && cyc >= pend[i].acc && cyc <= pend[i].acc + DW - 1) bexp = 1;
      chk("busy", int'(busy), bexp);
      if (done) begin
        if (pend.size() == 0) begin
          chk("unexpected done", 1, 0);
        end else begin
          ce = pend.pop_front();
          model(ce, cq, cr, cz);
          chk("done latency", cyc - ce.acc, lat(ce));
          chk("quotient", int'(quotient), cq);
          chk("remainder", int'(remainder), cr);
          chk("div_by_zero", int'(div_by_zero), cz);
          last_q = cq;
          last_r = cr;
          last_z = cz;
        end
      end else begin
        if (pend.size() > 0 && cyc > pend[0].acc + lat(pend[0])) begin
          ce = pend.pop_front();
          chk("done missing", 0, 1);
          model(ce, last_q, last_r, last_z);
        end
        chk("quotient hold", int'(quotient), last_q);
        chk("remainder hold", int'(remainder), last_r);
        chk("div_by_zero hold", int'(div_by_zero), last_z);
      end
`ifdef SEQ_DIVIDER_SELFCHECK_EN
      chk("chk_err", int'(chk_err), 0);
`endif
    end
  end

  task automatic drive_accept(input int a, input int b);
    op_t e;
    start    = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(b);
    @(posedge clk);
    #2;
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    e.dvd = a;
    e.dvs = b;
    e.acc = cyc;
    pend.push_back(e);
  endtask

  task automatic issue(input int a, input int b);
    @(posedge clk);
    #2;
    drive_accept(a, b);
  endtask

  task automatic chain(input int a, input int b);
    op_t p;
    int  target;
    p = pend[$];
    target = p.acc + ((p.dvs == 0) ? 0 : DW);
    while (cyc < target) begin
      @(posedge clk);
      #2;
    end
    drive_accept(a, b);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (pend.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (pend.size() > 0) begin
      chk("completion timeout", pend.size(), 0);
      pend.delete();
    end
  endtask

  task automatic expect_result(input string name, input int q, input int r, input int z);
    chk({name, " q"}, int'(quotient), q);
    chk({name, " r"}, int'(remainder), r);
    chk({name, " dbz"}, int'(div_by_zero), z);
  endtask

  task automatic expect_reset_outputs(input string name);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
    expect_result(name, 0, 0, 0);
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 rst_n = 1'b0;
    #1;
    expect_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;

    issue(45, 6); wait_empty(); expect_result("45/6", 7, 3, 0);
    issue(63, 7); wait_empty(); expect_result("63/7", 9, 0, 0);
    issue(5, 7);  wait_empty(); expect_result("5/7", 0, 5, 0);
    issue(0, 1);  wait_empty(); expect_result("0/1", 0, 0, 0);
    issue(20, 0); wait_empty(); expect_result("20/0", 63, 4, 1);
    issue(20, 5); wait_empty(); expect_result("20/5", 4, 0, 0);

    issue(50, 3);
    @(posedge clk);
    #2;
    start = 1'b1; dividend = 6'd9; divisor = 3'd2;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_empty(); expect_result("50/3 ignore", 16, 2, 0);

    issue(50, 3); chain(9, 2); wait_empty(); expect_result("9/2 b2b", 4, 1, 0);

    issue(45, 6);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    expect_reset_outputs("async reset");
    pend.delete();
    last_q = 0; last_r = 0; last_z = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(45, 6); wait_empty(); expect_result("45/6 after reset", 7, 3, 0);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        issue(a, b);
        wait_empty();
      end
    end

    for (int k = 0; k < 150; k++) begin
      int nchain;
      issue($urandom_range(0, 63), $urandom_range(0, 7));
      nchain = $urandom_range(0, 3);
      for (int j = 0; j < nchain; j++) chain($urandom_range(0, 63), $urandom_range(0, 7));
      wait_empty();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
